// File: rtl/decoder_2to4_seq.sv
// Registered 2-to-4 one-hot decoder with valid/ready handshakes
// and a self-sweep FSM that walks all four codes with idle gaps.
module decoder_2to4_seq #(
  parameter int unsigned HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [1:0] in_code,
  input  logic       in_en,
  output logic       in_ready,
  input  logic       sweep_start,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_onehot,
  output logic [1:0] out_code,
  output logic       busy,
  output logic       sweep_done,
  output logic [7:0] dec_count
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    GAP
  } state_t;

  state_t     r_state;
  logic [1:0] r_k;
  logic [7:0] r_gap;
  logic       r_out_valid;
  logic [3:0] r_onehot;
  logic [1:0] r_code;
  logic [7:0] r_cnt;
  logic       r_done;

  logic       w_free;
  logic       w_in_ready;
  logic       w_in_hs;
  logic       w_out_hs;
  logic [1:0] w_k_next;

  assign w_free     = ~r_out_valid | out_ready;
  assign w_in_ready = rst_n & (r_state == IDLE)
                    & ~sweep_start & w_free;
  assign w_in_hs    = in_valid & w_in_ready;
  assign w_out_hs   = r_out_valid & out_ready;
  assign w_k_next   = r_k + 2'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_k         <= 2'd0;
      r_gap       <= 8'd0;
      r_out_valid <= 1'b0;
      r_onehot    <= 4'b0000;
      r_code      <= 2'd0;
      r_cnt       <= 8'd0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_out_hs) begin
        r_cnt       <= r_cnt + 8'd1;
        r_out_valid <= 1'b0;
      end
      if (w_in_hs) begin
        r_onehot    <= in_en ? (4'b0001 << in_code) : 4'b0000;
        r_code      <= in_code;
        r_out_valid <= 1'b1;
      end
      unique case (r_state)
        IDLE: begin
          if (sweep_start) begin
            r_k     <= 2'd0;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          if (w_free) begin
            r_onehot    <= 4'b0001 << r_k;
            r_code      <= r_k;
            r_out_valid <= 1'b1;
            r_state     <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (w_out_hs) begin
            if (r_k == 2'd3) begin
              r_state <= IDLE;
              r_done  <= 1'b1;
            end else begin
              r_gap   <= HOLD[7:0];
              r_state <= GAP;
            end
          end
        end
        GAP: begin
          r_gap <= r_gap - 8'd1;
          // Output is known empty here, so the issue for the next
          // code is taken on the last gap cycle: exactly HOLD idle.
          if (r_gap == 8'd1) begin
            r_k         <= w_k_next;
            r_onehot    <= 4'b0001 << w_k_next;
            r_code      <= w_k_next;
            r_out_valid <= 1'b1;
            r_state     <= WAIT_ACK;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = r_out_valid;
  assign out_onehot = r_onehot;
  assign out_code   = r_code;
  assign busy       = (r_state != IDLE);
  assign sweep_done = r_done;
  assign dec_count  = r_cnt;

endmodule

// File: tb/tb_decoder_2to4_seq.sv
// Directed bench for decoder_2to4_seq: decode, backpressure,
// sweep with HOLD=2, reset abort and counter wrap.
module tb_decoder_2to4_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] in_code;
  logic       in_en;
  logic       in_ready;
  logic       sweep_start;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_onehot;
  logic [1:0] out_code;
  logic       busy;
  logic       sweep_done;
  logic [7:0] dec_count;

  int errors = 0;
  int checks = 0;

  decoder_2to4_seq #(.HOLD(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_code     (in_code),
    .in_en       (in_en),
    .in_ready    (in_ready),
    .sweep_start (sweep_start),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_onehot  (out_onehot),
    .out_code    (out_code),
    .busy        (busy),
    .sweep_done  (sweep_done),
    .dec_count   (dec_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got,
                       input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected post-edge observations for the HOLD=2 sweep
  int exp_ov [12] = '{1,0,0,1,0,0,1,0,0,1,0,0};
  int exp_oh [12] = '{1,0,0,2,0,0,4,0,0,8,0,0};
  int exp_oc [12] = '{0,0,0,1,0,0,2,0,0,3,0,0};
  int exp_sd [12] = '{0,0,0,0,0,0,0,0,0,0,1,0};
  int exp_bz [12] = '{1,1,1,1,1,1,1,1,1,1,0,0};
  int exp_st [4]  = '{1,2,4,8};

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b1;
    in_code     = 2'd3;
    in_en       = 1'b1;
    sweep_start = 1'b0;
    out_ready   = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 0);
    tick();
    tick();
    check("rst_in_ready2", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_onehot", out_onehot, 0);
    check("rst_code", out_code, 0);
    check("rst_count", dec_count, 0);
    check("rst_busy", busy, 0);
    check("rst_done", sweep_done, 0);

    // Streaming decode at full throughput
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_code = 2'(i);
      #1;
      check("stream_in_ready", in_ready, 1);
      tick();
      check("stream_onehot", out_onehot, exp_st[i]);
      check("stream_code", out_code, i);
      check("stream_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    tick();
    check("stream_drain_valid", out_valid, 0);
    check("stream_count", dec_count, 4);

    // Disabled decode
    in_en    = 1'b0;
    in_code  = 2'd2;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("dis_onehot", out_onehot, 0);
    check("dis_code", out_code, 2);
    check("dis_valid", out_valid, 1);
    tick();
    check("dis_count", dec_count, 5);

    // Backpressure holds the result
    in_en     = 1'b1;
    out_ready = 1'b0;
    in_code   = 2'd1;
    in_valid  = 1'b1;
    tick();
    in_code = 2'd3;
    #1;
    check("bp_in_ready", in_ready, 0);
    tick();
    tick();
    check("bp_onehot", out_onehot, 2);
    check("bp_code", out_code, 1);
    check("bp_valid", out_valid, 1);
    check("bp_count", dec_count, 5);
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("bp_replace_onehot", out_onehot, 8);
    check("bp_replace_valid", out_valid, 1);
    check("bp_replace_count", dec_count, 6);
    tick();
    check("bp_final_count", dec_count, 7);
    check("bp_final_valid", out_valid, 0);

    // Sweep wins over simultaneous input
    sweep_start = 1'b1;
    in_valid    = 1'b1;
    in_code     = 2'd0;
    #1;
    check("sw_in_ready", in_ready, 0);
    tick();
    sweep_start = 1'b0;
    in_valid    = 1'b0;
    check("sw_busy0", busy, 1);
    check("sw_valid0", out_valid, 0);
    for (int c = 0; c < 12; c++) begin
      tick();
      check("sw_valid", out_valid, exp_ov[c]);
      check("sw_done", sweep_done, exp_sd[c]);
      check("sw_busy", busy, exp_bz[c]);
      if (exp_ov[c] == 1) begin
        check("sw_onehot", out_onehot, exp_oh[c]);
        check("sw_code", out_code, exp_oc[c]);
      end
    end
    check("sw_count", dec_count, 11);

    // Reset during gap after code 1; sweep_start ignored mid-sweep
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    tick();
    tick();
    check("ab_gap_busy", busy, 1);
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    tick();
    check("ab_code1", out_code, 1);
    check("ab_onehot1", out_onehot, 2);
    tick();
    check("ab_in_gap", out_valid, 0);
    rst_n = 1'b0;
    tick();
    check("ab_busy", busy, 0);
    check("ab_valid", out_valid, 0);
    check("ab_count", dec_count, 0);
    check("ab_done", sweep_done, 0);
    rst_n = 1'b1;
    tick();
    check("ab_done_after", sweep_done, 0);
    check("ab_busy_after", busy, 0);

    // 256 handshakes wrap the counter
    in_valid = 1'b1;
    for (int n = 0; n < 256; n++) begin
      in_code = 2'(n);
      tick();
    end
    check("wrap_pre", dec_count, 255);
    in_valid = 1'b0;
    tick();
    check("wrap_count", dec_count, 0);
    check("wrap_valid", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
